// File: rtl/jtag_tap_sampled.sv
// jtag_tap_sampled: IEEE 1149.1 TAP responder. All JTAG pins are oversampled
// in the system clock domain. Provides a 5-bit IR, IDCODE, BYPASS and a 32-bit
// USER data register with a parallel capture/update port into core logic.
// Optional feature macro: JTAG_TRST_EN (enables io_jtag_TRSTn as a TAP reset).
// Handshake: there is no valid/ready pair; user_dr_update is a one-cycle strobe
// qualifying the new user_dr_out value, and TCK edges are inferred from samples.
module jtag_tap_sampled #(
  parameter logic [31:0] IDCODE = 32'h20000913
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_jtag_TCK,
  input  logic        io_jtag_TMS,
  input  logic        io_jtag_TDI,
  input  logic        io_jtag_TRSTn,
  output logic        io_jtag_TDO,
  input  logic [31:0] user_dr_in,
  output logic [31:0] user_dr_out,
  output logic        user_dr_update,
  output logic [3:0]  tap_state
);

  typedef enum logic [3:0] {
    TLR = 4'hF, RTI = 4'hC,
    SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR = 4'h2, EX1_DR = 4'h1,
    PAUSE_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
    SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR = 4'hA, EX1_IR = 4'h9,
    PAUSE_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
  } tap_state_t;

  localparam logic [4:0] INSTR_IDCODE = 5'h01;
  localparam logic [4:0] INSTR_USER   = 5'h10;

  logic       tck_s1, tck_s2, tck_prev;
  logic       tms_s1, tms_s2;
  logic       tdi_s1, tdi_s2;
  logic       tck_rise, tck_fall;

  tap_state_t state, next_state;
  logic [4:0]  ir, ir_sr;
  logic [31:0] dr_sr;
  logic        bp_sr;
  logic        sel_idcode, sel_user, sel_wide;

  // Two-flop synchronizers for the pins plus a third TCK stage for edge detect
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tck_s1 <= 1'b0; tck_s2 <= 1'b0; tck_prev <= 1'b0;
      tms_s1 <= 1'b0; tms_s2 <= 1'b0;
      tdi_s1 <= 1'b0; tdi_s2 <= 1'b0;
    end else begin
      tck_s1 <= io_jtag_TCK; tck_s2 <= tck_s1; tck_prev <= tck_s2;
      tms_s1 <= io_jtag_TMS; tms_s2 <= tms_s1;
      tdi_s1 <= io_jtag_TDI; tdi_s2 <= tdi_s1;
    end
  end

  assign tck_rise = tck_s2 & ~tck_prev;
  assign tck_fall = ~tck_s2 & tck_prev;

`ifdef JTAG_TRST_EN
  logic trst_s1, trst_s2;

  // Synchronize the active-low TAP reset pin
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      trst_s1 <= 1'b0;
      trst_s2 <= 1'b0;
    end else begin
      trst_s1 <= io_jtag_TRSTn;
      trst_s2 <= trst_s1;
    end
  end
`else
  // TRSTn stays on the interface but has no effect in this build
  logic unused_trst;
  assign unused_trst = io_jtag_TRSTn;
`endif

  assign sel_idcode = (ir == INSTR_IDCODE);
  assign sel_user   = (ir == INSTR_USER);
  assign sel_wide   = sel_idcode | sel_user;
  assign tap_state  = state;

  // Standard 1149.1 next-state table, evaluated with the synchronized TMS
  always_comb begin
    next_state = state;
    case (state)
      TLR:      next_state = tms_s2 ? TLR    : RTI;
      RTI:      next_state = tms_s2 ? SEL_DR : RTI;
      SEL_DR:   next_state = tms_s2 ? SEL_IR : CAP_DR;
      CAP_DR:   next_state = tms_s2 ? EX1_DR : SH_DR;
      SH_DR:    next_state = tms_s2 ? EX1_DR : SH_DR;
      EX1_DR:   next_state = tms_s2 ? UPD_DR : PAUSE_DR;
      PAUSE_DR: next_state = tms_s2 ? EX2_DR : PAUSE_DR;
      EX2_DR:   next_state = tms_s2 ? UPD_DR : SH_DR;
      UPD_DR:   next_state = tms_s2 ? SEL_DR : RTI;
      SEL_IR:   next_state = tms_s2 ? TLR    : CAP_IR;
      CAP_IR:   next_state = tms_s2 ? EX1_IR : SH_IR;
      SH_IR:    next_state = tms_s2 ? EX1_IR : SH_IR;
      EX1_IR:   next_state = tms_s2 ? UPD_IR : PAUSE_IR;
      PAUSE_IR: next_state = tms_s2 ? EX2_IR : PAUSE_IR;
      EX2_IR:   next_state = tms_s2 ? UPD_IR : SH_IR;
      UPD_IR:   next_state = tms_s2 ? SEL_DR : RTI;
      default:  next_state = TLR;
    endcase
  end

  // TAP FSM with IR/DR datapath: act in the current state on tck_rise, drive TDO on tck_fall
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= TLR;
      ir             <= INSTR_IDCODE;
      ir_sr          <= 5'h00;
      dr_sr          <= 32'h0;
      bp_sr          <= 1'b0;
      io_jtag_TDO    <= 1'b0;
      user_dr_out    <= 32'h0;
      user_dr_update <= 1'b0;
    end else begin
      user_dr_update <= 1'b0;
`ifdef JTAG_TRST_EN
      if (!trst_s2) begin
        state <= TLR;
        ir    <= INSTR_IDCODE;
      end else
`endif
      begin
        if (tck_rise) begin
          state <= next_state;
          case (state)
            CAP_IR: ir_sr <= 5'b00001;
            SH_IR:  ir_sr <= {tdi_s2, ir_sr[4:1]};
            UPD_IR: ir    <= ir_sr;
            CAP_DR: begin
              if (sel_idcode)    dr_sr <= IDCODE;
              else if (sel_user) dr_sr <= user_dr_in;
              else               bp_sr <= 1'b0;
            end
            SH_DR: begin
              if (sel_wide) dr_sr <= {tdi_s2, dr_sr[31:1]};
              else          bp_sr <= tdi_s2;
            end
            UPD_DR: begin
              if (sel_user) begin
                user_dr_out    <= dr_sr;
                user_dr_update <= 1'b1;
              end
            end
            default: ;
          endcase
          // Entering Test-Logic-Reset always restores the IDCODE instruction
          if (next_state == TLR) ir <= INSTR_IDCODE;
        end
        if (tck_fall) begin
          if (state == SH_DR)      io_jtag_TDO <= sel_wide ? dr_sr[0] : bp_sr;
          else if (state == SH_IR) io_jtag_TDO <= ir_sr[0];
          else                     io_jtag_TDO <= 1'b0;
        end
      end
    end
  end

endmodule
